// File: rtl/pe_align_pkg.sv
// pe_align_pkg: parameter defaults, width helper and derived widths shared by
// the alignment / accumulate / leading-sign-count stage.
package pe_align_pkg;

    // Ceiling log2, with clog2(1) = 0. Used for elaboration-time widths only.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    localparam int N_IN_DEF      = 16;
    localparam int MAN_W_DEF     = 26;
    localparam int GUARD_W_DEF   = 26;
    localparam int SH_W_DEF      = 10;
    localparam int EXP_W_DEF     = 10;
    localparam int ACC_GUARD_DEF = 8;

    // Derived widths at the defaults: ALIGN_W 52, SUM_W 57, ACC_W 65, CNT_W 7.
    localparam int ALIGN_W_DEF = MAN_W_DEF + GUARD_W_DEF;
    localparam int SUM_W_DEF   = ALIGN_W_DEF + 1 + clog2(N_IN_DEF);
    localparam int ACC_W_DEF   = SUM_W_DEF + ACC_GUARD_DEF;
    localparam int CNT_W_DEF   = clog2(ACC_W_DEF);

endpackage

// File: rtl/align_acc_lza_stage_lead_sign_count.sv
// lead_sign_count: normalisation shift of a two's-complement value, i.e. the
// number of bits directly below the MSB that repeat the MSB, plus a zero flag.
module lead_sign_count
    import pe_align_pkg::*;
#(
    parameter int  ACC_W = ACC_W_DEF,
    localparam int CNT_W = clog2(ACC_W)
) (
    input  logic [ACC_W-1:0] value,
    output logic [CNT_W-1:0] lza_cnt,
    output logic             lza_invalid
);

    // Scan downward from just below the MSB until the first bit that differs.
    always_comb begin
        logic run;
        // NOTE: every variable written here gets a value before the loop, so no latch is inferred.
        lza_cnt = '0;
        run     = 1'b1;
        // NOTE: blocking assignments here, so each iteration sees the previous iteration's result.
        for (int i = ACC_W - 2; i >= 0; i--) begin
            if (run && (value[i] == value[ACC_W-1])) begin
                lza_cnt = lza_cnt + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // A zero result carries no normalisation information; the count is ACC_W-1 then.
    assign lza_invalid = (value == '0);

endmodule

// File: rtl/align_acc_lza_stage.sv
// align_acc_lza_stage: aligns N_IN signed product mantissas to a common
// exponent, sums them per beat, optionally accumulates beats into a frame,
// and registers the frame result with its leading-sign count and flags.
module align_acc_lza_stage
    import pe_align_pkg::*;
#(
    parameter int  N_IN      = N_IN_DEF,
    parameter int  MAN_W     = MAN_W_DEF,
    parameter int  GUARD_W   = GUARD_W_DEF,
    parameter int  SH_W      = SH_W_DEF,
    parameter int  EXP_W     = EXP_W_DEF,
    parameter int  ACC_GUARD = ACC_GUARD_DEF,
    localparam int ALIGN_W   = MAN_W + GUARD_W,
    localparam int SUM_W     = ALIGN_W + 1 + clog2(N_IN),
    localparam int ACC_W     = SUM_W + ACC_GUARD,
    localparam int CNT_W     = clog2(ACC_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_acc_en,
    input  logic                  in_last,
    input  logic [N_IN-1:0]       in_sign,
    input  logic [N_IN*MAN_W-1:0] in_man,
    input  logic [N_IN*SH_W-1:0]  in_shift,
    input  logic [EXP_W-1:0]      in_exp_max,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_result,
    output logic                  out_sign,
    output logic [EXP_W-1:0]      out_exp_max,
    output logic [CNT_W-1:0]      out_lza_cnt,
    output logic                  out_lza_invalid,
    output logic                  out_ovf,
    output logic                  out_exp_err
);

    // Open-frame state.
    logic             frame_open;
    logic             acc_en_q;
    logic [EXP_W-1:0] exp_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic             exp_err_q;

    // Per-beat datapath.
    logic [SUM_W-1:0] beat_sum;
    logic [ACC_W-1:0] beat_ext;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] result_next;
    logic             add_ovf;

    // Frame control.
    logic             fire;
    logic             closing;
    logic             frame_acc_en;
    logic [EXP_W-1:0] frame_exp;
    logic             exp_diff;
    logic             ovf_next;
    logic             exp_err_next;
    logic [CNT_W-1:0] lza_cnt_next;
    logic             lza_invalid_next;

    // Align every term, apply its sign and add; SUM_W holds the exact total.
    always_comb begin
        logic [ALIGN_W-1:0] aligned;
        logic [SUM_W-1:0]   term;
        beat_sum = '0;
        aligned  = '0;
        term     = '0;
        for (int i = 0; i < N_IN; i++) begin
            aligned = {in_man[i*MAN_W +: MAN_W], {GUARD_W{1'b0}}};
            // Shifts that push the whole mantissa past the guard bits give zero.
            if (32'(in_shift[i*SH_W +: SH_W]) >= ALIGN_W) begin
                aligned = '0;
            end else begin
                aligned = aligned >> in_shift[i*SH_W +: SH_W];
            end
            term = SUM_W'(aligned);
            if (in_sign[i]) begin
                term = -term;
            end
            beat_sum = beat_sum + term;
        end
    end

    assign beat_ext = {{ACC_GUARD{beat_sum[SUM_W-1]}}, beat_sum};

    // Handshake: a held result blocks new beats only while it is not being taken.
    assign in_ready = !out_valid || out_ready;
    assign fire     = in_valid && in_ready;

    // Mode and exponent come from the beat that opens a frame and stay fixed after it.
    assign frame_acc_en = frame_open ? acc_en_q : in_acc_en;
    assign frame_exp    = frame_open ? exp_q    : in_exp_max;
    assign exp_diff     = frame_open && (in_exp_max != exp_q);

    // Running sum wraps at ACC_W; overflow is a sign flip of two like-signed operands.
    assign acc_base = frame_open ? acc_q : '0;
    assign acc_next = acc_base + beat_ext;
    assign add_ovf  = (acc_base[ACC_W-1] == beat_ext[ACC_W-1]) &&
                      (acc_next[ACC_W-1] != acc_base[ACC_W-1]);

    assign closing      = fire && (!frame_acc_en || in_last);
    assign result_next  = frame_acc_en ? acc_next : beat_ext;
    assign ovf_next     = frame_acc_en && (ovf_q || add_ovf);
    assign exp_err_next = exp_err_q || exp_diff;

    lead_sign_count #(
        .ACC_W (ACC_W)
    ) u_lead_sign_count (
        .value       (result_next),
        .lza_cnt     (lza_cnt_next),
        .lza_invalid (lza_invalid_next)
    );

    // Track the open accumulate frame; a closing beat returns everything to idle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks, so every register samples pre-edge values.
        if (rst) begin
            frame_open <= 1'b0;
            acc_en_q   <= 1'b0;
            exp_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            exp_err_q  <= 1'b0;
        end else if (fire) begin
            if (closing) begin
                frame_open <= 1'b0;
                acc_q      <= '0;
                ovf_q      <= 1'b0;
                exp_err_q  <= 1'b0;
            end else begin
                frame_open <= 1'b1;
                acc_en_q   <= frame_acc_en;
                exp_q      <= frame_exp;
                acc_q      <= acc_next;
                ovf_q      <= ovf_next;
                exp_err_q  <= exp_err_next;
            end
        end
    end

    // Output register: loaded by a closing beat, held until accepted.
    always_ff @(posedge clk) begin
        // NOTE: the data fields are reset too, so the port values are known before the first frame.
        if (rst) begin
            out_valid       <= 1'b0;
            out_result      <= '0;
            out_exp_max     <= '0;
            out_lza_cnt     <= '0;
            out_lza_invalid <= 1'b0;
            out_ovf         <= 1'b0;
            out_exp_err     <= 1'b0;
        end else if (closing) begin
            out_valid       <= 1'b1;
            out_result      <= result_next;
            out_exp_max     <= frame_exp;
            out_lza_cnt     <= lza_cnt_next;
            out_lza_invalid <= lza_invalid_next;
            out_ovf         <= ovf_next;
            out_exp_err     <= exp_err_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_sign = out_result[ACC_W-1];

endmodule

// File: tb/tb_align_acc_lza_stage.sv
// tb_align_acc_lza_stage: directed and randomized stimulus against an
// integer-arithmetic reference model, compared every cycle.
module tb_align_acc_lza_stage;

    localparam int N_IN    = 16;
    localparam int MAN_W   = 26;
    localparam int GUARD_W = 26;
    localparam int SH_W    = 10;
    localparam int EXP_W   = 10;
    localparam int ACC_W   = 65;
    localparam int CNT_W   = 7;

    typedef logic signed [127:0] wide_t;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_acc_en;
    logic                  in_last;
    logic [N_IN-1:0]       in_sign;
    logic [N_IN*MAN_W-1:0] in_man;
    logic [N_IN*SH_W-1:0]  in_shift;
    logic [EXP_W-1:0]      in_exp_max;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_W-1:0]      out_result;
    logic                  out_sign;
    logic [EXP_W-1:0]      out_exp_max;
    logic [CNT_W-1:0]      out_lza_cnt;
    logic                  out_lza_invalid;
    logic                  out_ovf;
    logic                  out_exp_err;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 0;

    bit rand_ready_on = 0;
    bit drv_ready     = 1;
    bit rnd_ready     = 1;
    assign out_ready = rand_ready_on ? rnd_ready : drv_ready;

    align_acc_lza_stage #(
        .N_IN      (N_IN),
        .MAN_W     (MAN_W),
        .GUARD_W   (GUARD_W),
        .SH_W      (SH_W),
        .EXP_W     (EXP_W),
        .ACC_GUARD (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_acc_en       (in_acc_en),
        .in_last         (in_last),
        .in_sign         (in_sign),
        .in_man          (in_man),
        .in_shift        (in_shift),
        .in_exp_max      (in_exp_max),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_sign        (out_sign),
        .out_exp_max     (out_exp_max),
        .out_lza_cnt     (out_lza_cnt),
        .out_lza_invalid (out_lza_invalid),
        .out_ovf         (out_ovf),
        .out_exp_err     (out_exp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit               m_open, m_acc_en, m_ovf, m_err;
    logic [EXP_W-1:0] m_exp;
    wide_t            m_acc;
    bit               mo_valid, mo_ovf, mo_err;
    wide_t            mo_res;
    logic [EXP_W-1:0] mo_exp;

    // Reduce an exact integer to its ACC_W-bit two's-complement value.
    function automatic wide_t wrap_acc(input wide_t x);
        logic signed [ACC_W-1:0] t;
        t = x[ACC_W-1:0];
        return wide_t'(t);
    endfunction

    // Exact signed sum of the current beat: man * 2^GUARD_W / 2^shift, truncated.
    function automatic wide_t model_beat_sum();
        wide_t total = 0;
        for (int i = 0; i < N_IN; i++) begin
            wide_t mag;
            mag = wide_t'(in_man[i*MAN_W +: MAN_W]);
            mag = (mag << GUARD_W) >> in_shift[i*SH_W +: SH_W];
            total = in_sign[i] ? total - mag : total + mag;
        end
        return total;
    endfunction

    // Normalisation shift = ACC_W-1 minus the magnitude bit length (of ~x when negative).
    function automatic int model_lza(input wide_t r);
        wide_t mag = (r < 0) ? ~r : r;
        int    len = 0;
        while (mag != 0) begin
            mag = mag >> 1;
            len++;
        end
        return ACC_W - 1 - len;
    endfunction

    always @(posedge clk) begin : model
        wide_t s, exact, lim;
        bit    fire;
        lim = wide_t'(1) <<< (ACC_W - 1);
        if (rst) begin
            m_open = 0; m_acc_en = 0; m_ovf = 0; m_err = 0; m_exp = '0; m_acc = 0;
            mo_valid = 0; mo_ovf = 0; mo_err = 0; mo_res = 0; mo_exp = '0;
        end else begin
            fire = in_valid && (!mo_valid || out_ready);
            if (mo_valid && out_ready) mo_valid = 0;
            if (fire) begin
                s = model_beat_sum();
                if (!m_open) begin
                    m_acc_en = in_acc_en; m_exp = in_exp_max;
                    m_acc = 0; m_ovf = 0; m_err = 0;
                end else if (in_exp_max != m_exp) begin
                    m_err = 1;
                end
                if (!m_acc_en) begin
                    mo_valid = 1; mo_res = wrap_acc(s); mo_exp = m_exp;
                    mo_ovf = 0; mo_err = 0; m_open = 0;
                end else begin
                    exact = m_acc + s;
                    if (exact >= lim || exact < -lim) m_ovf = 1;
                    m_acc = wrap_acc(exact);
                    if (in_last) begin
                        mo_valid = 1; mo_res = m_acc; mo_exp = m_exp;
                        mo_ovf = m_ovf; mo_err = m_err; m_open = 0;
                    end else begin
                        m_open = 1;
                    end
                end
            end
        end
    end

    // Every cycle: handshake always, payload whenever a result is expected.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("in_ready", in_ready, !mo_valid || out_ready);
            check("out_valid", out_valid, mo_valid);
            if (mo_valid) begin
                check("out_result", out_result, mo_res[ACC_W-1:0]);
                check("out_sign", out_sign, mo_res[ACC_W-1]);
                check("out_exp_max", out_exp_max, mo_exp);
                check("out_lza_cnt", out_lza_cnt, model_lza(mo_res));
                check("out_lza_invalid", out_lza_invalid, mo_res == 0);
                check("out_ovf", out_ovf, mo_ovf);
                check("out_exp_err", out_exp_err, mo_err);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- drivers ----------------
    task automatic clear_beat();
        in_sign   = '0;
        in_man    = '0;
        in_shift  = '0;
        in_acc_en = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic set_term(input int i, input logic [MAN_W-1:0] m, input logic [SH_W-1:0] sh,
                            input logic sg);
        in_man[i*MAN_W +: MAN_W] = m;
        in_shift[i*SH_W +: SH_W] = sh;
        in_sign[i]               = sg;
    endtask

    task automatic rand_terms();
        for (int i = 0; i < N_IN; i++) begin
            set_term(i, ($urandom_range(0, 3) == 0) ? '0 : MAN_W'($urandom),
                     SH_W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        end
    endtask

    // Present the current beat and return 1 ns after the edge it fires on.
    task automatic send_beat();
        int waited = 0;
        bit rdy;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 50) begin
                n_checks++;
                n_errors++;
                $display("FAIL send_timeout: in_ready low for %0d cycles", waited);
                break;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal;
    end

    initial begin : stimulus
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_exp_max = '0;
        clear_beat();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cmp_on = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_result", out_result, 0);
        check("rst_lza_cnt", out_lza_cnt, 0);
        check("rst_lza_invalid", out_lza_invalid, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_exp_err", out_exp_err, 0);
        @(posedge clk); #1;

        // All sixteen terms 2^25, unshifted, positive: 16 * 2^51 = 2^55.
        clear_beat();
        for (int i = 0; i < N_IN; i++) set_term(i, 26'h2000000, '0, 1'b0);
        in_exp_max = 10'd3;
        send_beat(); idle();
        @(negedge clk);
        check("d1_valid", out_valid, 1);
        check("d1_result", out_result, 128'h1 << 55);
        check("d1_lza_cnt", out_lza_cnt, 8);
        check("d1_lza_invalid", out_lza_invalid, 0);
        check("d1_exp_max", out_exp_max, 3);

        // Equal and opposite terms cancel.
        @(posedge clk); #1;
        clear_beat();
        set_term(0, 26'h2000000, '0, 1'b0);
        set_term(1, 26'h2000000, '0, 1'b1);
        send_beat(); idle();
        @(negedge clk);
        check("d2_result", out_result, 0);
        check("d2_lza_invalid", out_lza_invalid, 1);
        check("d2_lza_cnt", out_lza_cnt, 64);

        // Every term shifted out entirely.
        @(posedge clk); #1;
        clear_beat();
        for (int i = 0; i < N_IN; i++) set_term(i, MAN_W'($urandom), 10'd60, 1'($urandom_range(0, 1)));
        send_beat(); idle();
        @(negedge clk);
        check("d3_result", out_result, 0);
        check("d3_lza_invalid", out_lza_invalid, 1);

        // Three-beat accumulate frame, exponent differs on beat 2, acc_en dropped mid-frame.
        @(posedge clk); #1;
        clear_beat();
        set_term(0, 26'h2000000, '0, 1'b0);
        in_acc_en = 1'b1; in_exp_max = 10'd5;
        send_beat();
        in_acc_en = 1'b0; in_exp_max = 10'd6;
        send_beat();
        in_exp_max = 10'd5; in_last = 1'b1;
        send_beat(); idle();
        @(negedge clk);
        check("d4_valid", out_valid, 1);
        check("d4_result", out_result, 128'h3 << 51);
        check("d4_exp_err", out_exp_err, 1);
        check("d4_exp_max", out_exp_max, 5);
        check("d4_ovf", out_ovf, 0);

        // Back-pressure for four cycles, then a continuous stream.
        @(posedge clk); #1;
        drv_ready = 1'b0;
        clear_beat();
        set_term(0, 26'd1, '0, 1'b0);
        send_beat();
        clear_beat();
        set_term(0, 26'd2, '0, 1'b0);
        fork
            send_beat();
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_valid", out_valid, 1);
                    check("stall_result", out_result, 128'h1 << 26);
                end
                @(posedge clk);
                #1 drv_ready = 1'b1;
            end
        join
        for (int b = 0; b < 40; b++) begin
            clear_beat();
            rand_terms();
            in_exp_max = EXP_W'($urandom);
            send_beat();
        end
        idle();

        // Random frames, bubbles and back-pressure.
        rand_ready_on = 1'b1;
        for (int b = 0; b < 400; b++) begin
            clear_beat();
            rand_terms();
            in_acc_en  = ($urandom_range(0, 2) == 0);
            in_last    = ($urandom_range(0, 3) == 0);
            in_exp_max = ($urandom_range(0, 7) == 0) ? EXP_W'($urandom) : 10'd7;
            if ($urandom_range(0, 4) == 0) begin
                idle();
                @(posedge clk); #1;
            end
            send_beat();
        end
        clear_beat();
        in_acc_en = 1'b1; in_last = 1'b1;
        send_beat(); idle();
        rand_ready_on = 1'b0;
        drv_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 300 near-maximal positive beats overflow the 65-bit accumulator.
        clear_beat();
        for (int i = 0; i < N_IN; i++) set_term(i, 26'h3ffffff, '0, 1'b0);
        in_acc_en = 1'b1;
        for (int b = 0; b < 300; b++) begin
            in_last = (b == 299);
            send_beat();
        end
        idle();
        @(negedge clk);
        check("ovf_valid", out_valid, 1);
        check("ovf_flag", out_ovf, 1);

        // Reset in the middle of a frame discards it.
        @(posedge clk); #1;
        clear_beat();
        set_term(0, 26'h2000000, '0, 1'b0);
        in_acc_en = 1'b1;
        send_beat();
        send_beat();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_no_output", out_valid, 0);
        @(posedge clk); #1;
        in_last = 1'b1;
        send_beat(); idle();
        @(negedge clk);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_result", out_result, 128'h1 << 51);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
